// File: rtl/c3lib_ckdiv_gate_nch.sv
// N-channel programmable clock divider/gater with per-channel req/ack and glitch-free start/stop.
// Optional phase-alignment input sync_in is present only when C3LIB_CKDIV_SYNC_EN is defined.
module c3lib_ckdiv_gate_nch #(
    parameter int unsigned NCH  = 2,
    parameter int unsigned DIVW = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH*DIVW-1:0] div_ratio,
    input  logic [NCH-1:0]      en_req,
`ifdef C3LIB_CKDIV_SYNC_EN
    input  logic                sync_in,
`endif
    output logic [NCH-1:0]      en_ack,
    output logic [NCH-1:0]      ck_out,
    output logic [NCH-1:0]      ck_rise
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} st_e;

    localparam logic [DIVW-1:0] RMin = DIVW'(2);
    localparam logic [DIVW-1:0] ROne = DIVW'(1);
    localparam logic [DIVW-1:0] RZero = '0;

    logic sync_c;
`ifdef C3LIB_CKDIV_SYNC_EN
    assign sync_c = sync_in;
`else
    assign sync_c = 1'b0;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        st_e             st_q;
        logic [DIVW-1:0] cnt_q;
        logic [DIVW-1:0] r_act_q;
        logic            ack_q;
        logic            ck_q;
        logic            rise_q;

        logic [DIVW-1:0] ratio_raw;
        logic [DIVW-1:0] ratio_c;
        logic [DIVW-1:0] cnt_inc;
        logic            last_c;
        logic            hi_next_c;

        assign ratio_raw = div_ratio[i*DIVW +: DIVW];
        assign ratio_c   = (ratio_raw < RMin) ? RMin : ratio_raw;
        assign cnt_inc   = cnt_q + ROne;
        assign last_c    = (cnt_q == (r_act_q - ROne));
        // High phase covers the first floor(R/2) counts of each period.
        assign hi_next_c = (cnt_inc < (r_act_q >> 1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q    <= StIdle;
                cnt_q   <= RZero;
                r_act_q <= RMin;
                ack_q   <= 1'b0;
                ck_q    <= 1'b0;
                rise_q  <= 1'b0;
            end else begin
                unique case (st_q)
                    StRun, StDrain: begin
                        if (last_c && !en_req[i]) begin
                            // Period complete with no request: park low; beats a sync restart.
                            st_q    <= StIdle;
                            cnt_q   <= RZero;
                            r_act_q <= ratio_c;
                            ack_q   <= 1'b0;
                            ck_q    <= 1'b0;
                            rise_q  <= 1'b0;
                        end else if (last_c || sync_c) begin
                            st_q    <= en_req[i] ? StRun : StDrain;
                            cnt_q   <= RZero;
                            r_act_q <= ratio_c;
                            ack_q   <= 1'b1;
                            ck_q    <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            st_q    <= en_req[i] ? StRun : StDrain;
                            cnt_q   <= cnt_inc;
                            ack_q   <= 1'b1;
                            ck_q    <= hi_next_c;
                            rise_q  <= 1'b0;
                        end
                    end
                    default: begin
                        cnt_q   <= RZero;
                        r_act_q <= ratio_c;
                        if (en_req[i]) begin
                            st_q   <= StRun;
                            ack_q  <= 1'b1;
                            ck_q   <= 1'b1;
                            rise_q <= 1'b1;
                        end else begin
                            st_q   <= StIdle;
                            ack_q  <= 1'b0;
                            ck_q   <= 1'b0;
                            rise_q <= 1'b0;
                        end
                    end
                endcase
            end
        end

        assign en_ack[i]  = ack_q;
        assign ck_out[i]  = ck_q;
        assign ck_rise[i] = rise_q;
    end

endmodule
